// File: rtl/bfm_ahbl_slave.sv
// bfm_ahbl_slave: AHB-Lite memory slave with fixed wait states and two-cycle ERROR responses
module bfm_ahbl_slave #(
  parameter int AWIDTH      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETN,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADYIN,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [AWIDTH+1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic [31:0]       mem [2**AWIDTH];
  logic              take, illegal;
  logic [3:0]        be;
  logic              unused;
  assign unused = ^{HBURST, HTRANS[0], HADDR[31:AWIDTH+2], HSIZE[2]};
  always_comb begin
    take    = (state_q == S_IDLE || state_q == S_DATA || state_q == S_ERR2) && HSEL && HREADYIN && HTRANS[1];
    illegal = HSIZE > 3'd2 || (HSIZE == 3'd1 && HADDR[0]) || (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);
    state_d = take ? (illegal ? S_ERR1 : WAIT_STATES > 0 ? S_WAIT : S_DATA)
            : state_q == S_ERR1 ? S_ERR2
            : state_q == S_WAIT ? (cnt_q == 4'd1 ? S_DATA : S_WAIT)
            : S_IDLE;
    cnt_d   = take ? (illegal ? 4'd0 : 4'(WAIT_STATES)) : state_q == S_WAIT ? cnt_q - 4'd1 : cnt_q;
    addr_d  = take ? HADDR[AWIDTH+1:0] : addr_q;
    write_d = take ? HWRITE : write_q;
    size_d  = take ? HSIZE[1:0] : size_q;
    be      = size_q == 2'd0 ? 4'b0001 << addr_q[1:0]
            : size_q == 2'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011)
            : 4'b1111;
  end
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end
  // state_q is forced to IDLE asynchronously, so a write cut short by reset never commits
  always_ff @(posedge HCLK) begin
    if (state_q == S_DATA && write_q)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[addr_q[AWIDTH+1:2]][8*i +: 8] <= HWDATA[8*i +: 8];
  end
  assign HREADYOUT = !(state_q == S_WAIT || state_q == S_ERR1);
  assign HRESP     = state_q == S_ERR1 || state_q == S_ERR2;
  assign HRDATA    = (state_q == S_DATA && !write_q) ? mem[addr_q[AWIDTH+1:2]] : '0;
endmodule

// File: tb/tb_bfm_ahbl_slave.sv
// tb_bfm_ahbl_slave: random and directed AHB-Lite traffic against a byte-level memory model
module tb_bfm_ahbl_slave;
  localparam int AW    = 10;
  localparam int WS    = 3;
  localparam int MSPAN = 1 << (AW + 2);
  typedef struct packed { logic err; logic [31:0] rdata; } exp_t;
  logic        hclk = 0, hresetn = 0, hsel = 0, hwrite = 0, stall = 0;
  logic [31:0] haddr = 0, hwdata = 0;
  logic [1:0]  htrans = 0;
  logic [2:0]  hsize = 0, hburst = 0;
  logic        hreadyin, hreadyout, hresp;
  logic [31:0] hrdata;
  exp_t        q[$];
  logic [7:0]  mb [int];
  int          compared = 0, mismatched = 0;
  logic        hr = 1, dp_dut = 0;
  logic [31:0] pend_wd = 0;
  assign hreadyin = hreadyout & ~stall;
  always #5 hclk = ~hclk;
  bfm_ahbl_slave #(.AWIDTH(AW), .WAIT_STATES(WS)) dut (
    .HCLK(hclk), .HRESETN(hresetn), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADYIN(hreadyin), .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata)
  );
  task automatic check(input string nm, input logic [33:0] a, input logic [33:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: {ready,resp,rdata} got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask
  // Memory as a byte map: a transfer of 2^size bytes at an aligned address, modulo the aliasing span
  function automatic exp_t model(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                                 input logic [31:0] wd, input bit ap);
    exp_t e;
    int   base;
    e.err   = 1'b0;
    e.rdata = '0;
    if (sz > 3'd2 || (a % (32'd1 << sz)) != 0) begin
      e.err = 1'b1;
      return e;
    end
    base = int'(a % 32'(MSPAN));
    if (wr) begin
      if (ap)
        for (int i = 0; i < (1 << sz); i++) mb[base + i] = wd[8*((base + i) % 4) +: 8];
    end else
      for (int i = 0; i < 4; i++) e.rdata[8*i +: 8] = mb[(base & ~3) + i];
    return e;
  endfunction
  task automatic step_present(input logic sel, input logic [1:0] tr, input logic wr, input logic [31:0] a,
                              input logic [2:0] sz, input logic [31:0] wd, input bit ap);
    int n = 0;
    do begin
      @(negedge hclk);
      hr = hreadyin;
      @(posedge hclk);
      #1;
      n++;
      if (!hr) stall = !dp_dut && $urandom_range(0, 3) == 0;
    end while (!hr && n < 64);
    if (!hr) begin
      compared++;
      mismatched++;
      $display("FAIL ready_timeout: HREADY low for %0d cycles, required high within 64", n);
    end
    dp_dut  = hsel && htrans[1];
    hwdata  = pend_wd;
    pend_wd = wd;
    hsel    = sel;
    htrans  = tr;
    hwrite  = wr;
    haddr   = a;
    hsize   = sz;
    hburst  = 3'($urandom_range(0, 7));
    if (sel && tr[1]) q.push_back(model(wr, a, sz, wd, ap));
    stall = !dp_dut && $urandom_range(0, 3) == 0;
  endtask
  task automatic xf(input logic wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    step_present(1'b1, 2'b10, wr, a, sz, wd, 1'b1);
  endtask
  initial begin : monitor
    exp_t        cur;
    int          k, low;
    bit          active;
    logic [33:0] ev;
    active = 0;
    k      = 0;
    cur    = '0;
    forever begin
      @(negedge hclk);
      if (!hresetn) begin
        active = 0;
        ev     = {1'b1, 1'b0, 32'h0};
      end else if (active) begin
        low = cur.err ? 1 : WS;
        ev  = k < low ? {1'b0, cur.err, 32'h0} : {1'b1, cur.err, cur.err ? 32'h0 : cur.rdata};
        if (k >= low) active = 0;
        else k++;
      end else ev = {1'b1, 1'b0, 32'h0};
      check("response", {hreadyout, hresp, hrdata}, ev);
      if (hresetn && hsel && htrans[1] && hreadyin) begin
        if (q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL accept: transfer accepted at %0t with no expected entry queued", $time);
        end else begin
          cur    = q.pop_front();
          active = 1;
          k      = 0;
        end
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required finish before it");
    $fatal(1, "watchdog expired");
  end
  initial begin
    repeat (3) @(posedge hclk);
    #1 hresetn = 1;
    for (int i = 0; i < 32; i++) xf(1'b1, 32'(i * 4), 3'd2, $urandom);
    xf(1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    xf(1'b0, 32'h10, 3'd2, 32'h0);
    xf(1'b0, 32'h10, 3'd2, 32'h0);
    xf(1'b1, 32'h20, 3'd0, {4{8'h11}});
    xf(1'b1, 32'h21, 3'd0, {4{8'h22}});
    xf(1'b1, 32'h22, 3'd0, {4{8'h33}});
    xf(1'b1, 32'h23, 3'd0, {4{8'h44}});
    xf(1'b0, 32'h20, 3'd2, 32'h0);
    xf(1'b1, 32'h22, 3'd1, {2{16'hAAAA}});
    xf(1'b0, 32'h20, 3'd2, 32'h0);
    xf(1'b1, 32'h21, 3'd2, 32'hFFFFFFFF);
    xf(1'b0, 32'h20, 3'd2, 32'h0);
    xf(1'b0, 32'h20, 3'd3, 32'h0);
    xf(1'b1, 32'h22, 3'd1, 32'h0);
    xf(1'b1, 32'h1000, 3'd2, 32'h12345678);
    xf(1'b0, 32'h0000, 3'd2, 32'h0);
    step_present(1'b1, 2'b10, 1'b1, 32'h30, 3'd2, 32'hBAD0BAD0, 1'b0);
    step_present(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h0, 1'b1);
    #2;
    check("wait_before_reset", {hreadyout, hresp, hrdata}, {1'b0, 1'b0, 32'h0});
    hresetn = 0;
    #1;
    check("async_reset", {hreadyout, hresp, hrdata}, {1'b1, 1'b0, 32'h0});
    @(negedge hclk);
    @(posedge hclk);
    #1 hresetn = 1;
    xf(1'b0, 32'h30, 3'd2, 32'h0);
    for (int n = 0; n < 400; n++) begin
      logic [2:0]  sz;
      logic [1:0]  off;
      logic [31:0] a;
      sz  = $urandom_range(0, 9) == 0 ? 3'd3 : 3'($urandom_range(0, 2));
      off = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) != 0) off = sz == 3'd0 ? off : sz == 3'd1 ? {off[1], 1'b0} : 2'b00;
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2) | 32'(off);
      step_present($urandom_range(0, 4) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   a, sz, $urandom, 1'b1);
    end
    repeat (4) step_present(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h0, 1'b1);
    repeat (WS + 3) @(negedge hclk);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL queue_drained: %0d expected responses left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/bfm_ahbl_slave.md
BFM_AHBL_SLAVE -- requirements
Module: bfm_ahbl_slave

Interface
REQ-001 The block SHALL have parameter AWIDTH, default 10, giving the word-address width (memory depth = 2^AWIDTH 32-bit words).
REQ-002 The block SHALL have parameter WAIT_STATES, default 0, range 0-15, giving the number of wait cycles inserted per OKAY transfer.
REQ-003 The block SHALL have port HCLK, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port HRESETN, input, 1 bit, the reset, which is asynchronous and active-low.
REQ-005 The block SHALL have port HSEL, input, 1 bit, the slave select.
REQ-006 The block SHALL have port HADDR, input, 32 bits, the address.
REQ-007 The block SHALL have port HTRANS, input, 2 bits, the transfer type (IDLE, BUSY, NONSEQ, SEQ).
REQ-008 The block SHALL have port HWRITE, input, 1 bit; 1 = write.
REQ-009 The block SHALL have port HSIZE, input, 3 bits, the transfer size.
REQ-010 The block SHALL have port HBURST, input, 3 bits; it is ignored and is present for bus compatibility only.
REQ-011 The block SHALL have port HWDATA, input, 32 bits, the write data.
REQ-012 The block SHALL have port HREADYIN, input, 1 bit, the bus-level HREADY.
REQ-013 The block SHALL have port HREADYOUT, output, 1 bit, the slave ready.
REQ-014 The block SHALL have port HRESP, output, 1 bit; 0 = OKAY, 1 = ERROR.
REQ-015 The block SHALL have port HRDATA, output, 32 bits, the read data.

Function
REQ-016 Address phase: the block SHALL accept an address phase on a rising edge where HSEL=1, HREADYIN=1 and HTRANS[1]=1, capturing HADDR, HWRITE and HSIZE; all other edges SHALL accept no transfer.
REQ-017 State machine: the block SHALL implement the states IDLE, WAIT, DATA, ERR1 and ERR2.
REQ-018 From IDLE, an accepted legal transfer SHALL go to WAIT when WAIT_STATES>0, otherwise to DATA.
REQ-019 An illegal transfer SHALL go to ERR1 with no wait states.
REQ-020 A transfer SHALL be illegal if HSIZE>2, or if HSIZE=1 with HADDR[0]=1, or if HSIZE=2 with HADDR[1:0]!=0.
REQ-021 In WAIT, a 4-bit counter loaded with WAIT_STATES SHALL decrement once per cycle, and the block SHALL go to DATA when the count reaches 1.
REQ-022 In WAIT, HREADYOUT SHALL be 0 and HRESP SHALL be 0.
REQ-023 In DATA, HREADYOUT SHALL be 1 and HRESP SHALL be 0; the next state SHALL follow the same acceptance rules as IDLE, so back-to-back transfers have no idle cycle.
REQ-024 In ERR1, HREADYOUT SHALL be 0 and HRESP SHALL be 1, and the block SHALL always go to ERR2, even if HTRANS changes during ERR1.
REQ-025 In ERR2, HREADYOUT SHALL be 1 and HRESP SHALL be 1; ERR2 SHALL accept a new address phase exactly as DATA does.
REQ-026 In IDLE, HREADYOUT SHALL be 1 and HRESP SHALL be 0.
REQ-027 Memory index: the word index SHALL be the captured HADDR[AWIDTH+1:2]; higher address bits SHALL be ignored, so addresses alias (wrap) modulo 2^(AWIDTH+2).
REQ-028 Writes SHALL commit on the rising edge that ends DATA, sampling HWDATA in that cycle.
REQ-029 Write byte lanes SHALL be little-endian: a byte write updates lane HADDR[1:0], a halfword write updates lanes {HADDR[1],0} and {HADDR[1],1}, and a word write updates all four lanes; other lanes SHALL be unchanged.
REQ-030 Reads: HRDATA SHALL equal the full 32-bit word at the captured index while in DATA with a captured read, and 0 otherwise.
REQ-031 Read-after-write to the same word in consecutive transfers SHALL return the newly written data.
REQ-032 ERROR transfers SHALL NOT modify memory, and HRDATA SHALL be 0 during ERR1 and ERR2.

Reset
REQ-033 While HRESETN=0, the block SHALL be in state IDLE with HREADYOUT=1, HRESP=0, HRDATA=0, the wait counter at 0 and the captured controls cleared.
REQ-034 Memory contents SHALL NOT be reset.
REQ-035 A reset asserted mid-transfer (WAIT, DATA, ERR1 or ERR2) SHALL abandon the transfer immediately, and a pending write SHALL NOT be committed.

Verification
REQ-036 With WAIT_STATES=0: a word write of 0xDEADBEEF to 0x10 followed by a word read of 0x10 -> HREADYOUT stays 1 on every cycle, and the read data phase gives HRDATA=0xDEADBEEF.
REQ-037 With WAIT_STATES=3: a read of 0x10 -> HREADYOUT is low for exactly 3 cycles, then high for 1 cycle with HRDATA=0xDEADBEEF.
REQ-038 Byte writes of 0x11, 0x22, 0x33 and 0x44 to 0x20, 0x21, 0x22 and 0x23, then a word read of 0x20 -> HRDATA=0x44332211; a halfword write of 0xAAAA to 0x22 -> the next read gives 0xAAAA2211.
REQ-039 A word write to 0x21 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); a read of 0x20 afterwards gives an unchanged value; an HSIZE=3 transfer also gives the two-cycle ERROR response.
REQ-040 With AWIDTH=10: a write of 0x12345678 to 0x1000 -> a read of 0x0000 returns 0x12345678 (alias).
REQ-041 With WAIT_STATES=2: HRESETN is pulsed low during WAIT of a write to 0x30 -> HREADYOUT=1 and HRESP=0 asynchronously, and a later read of 0x30 shows the old contents.
